platform_collision_scanner: RTL
===============================

Name: platform_collision_scanner

Overview:
- Sequential, parametrised generalisation of the all-platforms collision check.
- Walks a platform table of N_PLAT entries, one entry per clock, instead of evaluating a fixed 16-way combinational OR.
- Returns the OR-ed collision code plus the index of the first colliding platform, under a start/done handshake.
- Sits between the player-movement FSMs (Tom, Jerry) and the level platform ROM.

Parameters:
- N_PLAT, 16, number of platform table entries; must be >= 1.
- COORD_W, 10, coordinate width in bits.
- SIZE_W, 8, width of the object width/height and platform-length inputs.
- SCREEN_W, 1023, right screen bound (used only with the optional clamp).
- SCREEN_H, 767, bottom screen bound (used only with the optional clamp).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- obj_x  in  COORD_W  object left x; sampled on an accepted start.
- obj_y  in  COORD_W  object top y; sampled on an accepted start.
- obj_w  in  SIZE_W  object width; sampled on an accepted start.
- obj_h  in  SIZE_W  object height; sampled on an accepted start.
- plat_idx  out  IDX_W=$clog2(N_PLAT) (min 1)  table address.
- plat_x  in  COORD_W  platform start x; combinational table data for plat_idx.
- plat_y  in  COORD_W  platform collision y; combinational table data for plat_idx.
- plat_len  in  SIZE_W  platform length; combinational table data for plat_idx.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  2  collision code: 11 side, 10 from above, 01 from below, 00 none.
- hit_valid  out  1  at least one platform collided.
- hit_idx  out  IDX_W  lowest index with a non-zero per-platform code.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE: on start=1, latch obj_*, clear the accumulators, set plat_idx=0, move to SCAN. Leave result, hit_valid and hit_idx unchanged until the scan completes.
- SCAN: busy=1. Each cycle, evaluate the entry at the current plat_idx and OR its code into the accumulator.
  - If the entry's code is non-zero and no hit has been recorded yet, record plat_idx as the hit.
  - If plat_idx==N_PLAT-1, go to DONE; otherwise increment plat_idx.
- DONE: register result, hit_valid and hit_idx; done=1 for exactly this cycle; next state is IDLE.
- Outputs hold their values until the next DONE.
- Latency: start accepted at cycle 0 gives done at cycle N_PLAT+1.
- start while busy or in DONE is ignored; no queuing.
- Per-platform code, with priority side > above > below:
  - side: (x==px+len || x+w==px) && y+h>=py && y<=py.
  - above: y+h==py && x+w>=px && x<=px+len.
  - below: y==py && x+w>=px && x<=px+len.
- All sums are computed at COORD_W+1 bits; no truncation or wrap-around.
- Asynchronous reset mid-scan returns to IDLE, drops busy, zeroes outputs, and emits no done.

Optional Feature:
- Macro: COLLISION_CLAMP_EN.
- Defined:
  - Latched obj_x is clamped: 0 becomes 1; obj_x+obj_w>SCREEN_W becomes SCREEN_W-obj_w.
  - obj_y is clamped the same way against SCREEN_H.
  - The scan uses the clamped values.
  - Extra outputs clamp_x and clamp_y (COORD_W each) are registered at DONE; reset value 0.
- Undefined: raw coordinates are used, and the clamp_x/clamp_y ports do not exist.

Decomposition:
- game_pkg holds:
  - the collision code constants COLL_NONE/COLL_BELOW/COLL_ABOVE/COLL_SIDE;
  - typedef plat_desc_t {x, y, len};
  - screen bound constants.
- One sub-module, plat_collision_eval: purely combinational evaluation of a single platform against the object, producing a 2-bit code.
- The level platform ROM stays outside this block.

Test Plan:
All cases use N_PLAT=4, obj 40x50, and entry 2 = {x=100, y=400, len=200}; other entries are far away.
- obj (150,350) -> done at cycle 5, result=10, hit_valid=1, hit_idx=2.
- obj (60,380) -> result=11, hit_idx=2.
- obj (150,400) -> result=01.
- obj (500,100) -> result=00, hit_valid=0.
- Entries 1 and 2 both hit from above -> hit_idx=1, result=10.
- start re-pulsed at cycle 2 -> ignored, single done at cycle 5.
- rst at cycle 3 -> busy=0 immediately, no done.
- With COLLISION_CLAMP_EN: obj (1000,0) with w=40 -> clamp_x=983, clamp_y=1.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared collision codes, platform descriptor and screen bounds
//
// Purpose: constants and types shared by the platform collision scanner and
// its per-platform evaluator. No ports.
//
// COLL_* codes are ordered by priority: side > above > below > none.

package game_pkg;

  localparam logic [1:0] COLL_NONE  = 2'b00;
  localparam logic [1:0] COLL_BELOW = 2'b01;
  localparam logic [1:0] COLL_ABOVE = 2'b10;
  localparam logic [1:0] COLL_SIDE  = 2'b11;

  localparam int SCREEN_W_DEF = 1023;
  localparam int SCREEN_H_DEF = 767;

  // Platform ROM entry layout at the default 10-bit coordinate / 8-bit length widths.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] len;
  } plat_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/plat_collision_eval.sv
// rtl/plat_collision_eval.sv - combinational collision test of one platform against the object
//
// Ports:
//   x_i, y_i    object left / top coordinate
//   w_i, h_i    object width / height
//   px_i, py_i  platform start x / collision y
//   len_i       platform length
//   code_o      2-bit collision code (COLL_SIDE > COLL_ABOVE > COLL_BELOW > COLL_NONE)
//
// All edge sums are one bit wider than a coordinate so they never wrap.

module plat_collision_eval
  import game_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int SIZE_W  = 8
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [SIZE_W-1:0]  w_i,
  input  logic [SIZE_W-1:0]  h_i,
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [SIZE_W-1:0]  len_i,
  output logic [1:0]         code_o
);

  localparam int S_W = COORD_W + 1;
  localparam int PAD = S_W - SIZE_W;

  logic [S_W-1:0] x_e, y_e, px_e, py_e;
  logic [S_W-1:0] x_end, y_end, p_end;
  logic           x_span, side, above, below;

  assign x_e   = {1'b0, x_i};
  assign y_e   = {1'b0, y_i};
  assign px_e  = {1'b0, px_i};
  assign py_e  = {1'b0, py_i};
  assign x_end = x_e + {{PAD{1'b0}}, w_i};
  assign y_end = y_e + {{PAD{1'b0}}, h_i};
  assign p_end = px_e + {{PAD{1'b0}}, len_i};

  // Horizontal extents touch or overlap (inclusive at both ends).
  assign x_span = (x_end >= px_e) && (x_e <= p_end);

  assign side  = ((x_e == p_end) || (x_end == px_e)) && (y_end >= py_e) && (y_e <= py_e);
  assign above = (y_end == py_e) && x_span;
  assign below = (y_e == py_e) && x_span;

  always_comb begin
    code_o = COLL_NONE;
    if (side)       code_o = COLL_SIDE;
    else if (above) code_o = COLL_ABOVE;
    else if (below) code_o = COLL_BELOW;
  end

endmodule

// File: rtl/platform_collision_scanner.sv
// rtl/platform_collision_scanner.sv - sequential scan of a platform table for object collisions
//
// Walks N_PLAT table entries, one per clock, OR-ing per-platform collision
// codes and recording the lowest colliding index. Optional macro
// COLLISION_CLAMP_EN clamps the latched object position to the screen and
// adds the clamp_x / clamp_y outputs.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     request pulse, accepted only when idle
//   obj_x, obj_y, obj_w, obj_h object box, sampled on an accepted start
//   plat_idx                  table address driven to the platform ROM
//   plat_x, plat_y, plat_len  combinational ROM data for plat_idx
//   busy                      scan in progress
//   done                      one-cycle pulse, result valid
//   result                    OR-ed collision code
//   hit_valid, hit_idx        any hit / lowest colliding index
//   clamp_x, clamp_y          clamped object position (COLLISION_CLAMP_EN only)

module platform_collision_scanner
  import game_pkg::*;
#(
  parameter int N_PLAT   = 16,
  parameter int COORD_W  = 10,
  parameter int SIZE_W   = 8,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  localparam int IDX_W   = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [SIZE_W-1:0]  obj_w,
  input  logic [SIZE_W-1:0]  obj_h,
  output logic [IDX_W-1:0]   plat_idx,
  input  logic [COORD_W-1:0] plat_x,
  input  logic [COORD_W-1:0] plat_y,
  input  logic [SIZE_W-1:0]  plat_len,
  output logic               busy,
  output logic               done,
  output logic [1:0]         result,
  output logic               hit_valid,
  output logic [IDX_W-1:0]   hit_idx
`ifdef COLLISION_CLAMP_EN
  ,
  output logic [COORD_W-1:0] clamp_x,
  output logic [COORD_W-1:0] clamp_y
`endif
);

  if (N_PLAT < 1 || SIZE_W > COORD_W || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_param
    $error("platform_collision_scanner: illegal parameter combination");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLAT - 1);

  scan_state_t        state_q, state_d;
  logic [COORD_W-1:0] obj_x_q, obj_x_d, obj_y_q, obj_y_d;
  logic [SIZE_W-1:0]  obj_w_q, obj_w_d, obj_h_q, obj_h_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         acc_q, acc_d;
  logic               acc_hit_q, acc_hit_d;
  logic [IDX_W-1:0]   acc_idx_q, acc_idx_d;
  logic [1:0]         result_q, result_d;
  logic               hit_valid_q, hit_valid_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [COORD_W-1:0] x_in, y_in;
  logic [1:0]         code;
  logic               last;

  assign last = (idx_q == LAST_IDX);

`ifdef COLLISION_CLAMP_EN
  logic [COORD_W-1:0] clamp_x_q, clamp_x_d, clamp_y_q, clamp_y_d;
  logic [COORD_W:0]   x_end, y_end, x_fit, y_fit;
  localparam logic [COORD_W:0] SCR_W = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] SCR_H = (COORD_W+1)'(SCREEN_H);

  // Overflow past the far edge pulls the object back flush to the bound;
  // a zero coordinate is nudged to 1.
  assign x_end = {1'b0, obj_x} + {{(COORD_W+1-SIZE_W){1'b0}}, obj_w};
  assign y_end = {1'b0, obj_y} + {{(COORD_W+1-SIZE_W){1'b0}}, obj_h};
  assign x_fit = SCR_W - {{(COORD_W+1-SIZE_W){1'b0}}, obj_w};
  assign y_fit = SCR_H - {{(COORD_W+1-SIZE_W){1'b0}}, obj_h};
  assign x_in  = (x_end > SCR_W) ? x_fit[COORD_W-1:0] :
                 (obj_x == '0)   ? COORD_W'(1) : obj_x;
  assign y_in  = (y_end > SCR_H) ? y_fit[COORD_W-1:0] :
                 (obj_y == '0)   ? COORD_W'(1) : obj_y;
`else
  assign x_in = obj_x;
  assign y_in = obj_y;
`endif

  plat_collision_eval #(
    .COORD_W (COORD_W),
    .SIZE_W  (SIZE_W)
  ) u_eval (
    .x_i    (obj_x_q),
    .y_i    (obj_y_q),
    .w_i    (obj_w_q),
    .h_i    (obj_h_q),
    .px_i   (plat_x),
    .py_i   (plat_y),
    .len_i  (plat_len),
    .code_o (code)
  );

  // State register plus datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      obj_x_q     <= '0;
      obj_y_q     <= '0;
      obj_w_q     <= '0;
      obj_h_q     <= '0;
      idx_q       <= '0;
      acc_q       <= COLL_NONE;
      acc_hit_q   <= 1'b0;
      acc_idx_q   <= '0;
      result_q    <= COLL_NONE;
      hit_valid_q <= 1'b0;
      hit_idx_q   <= '0;
`ifdef COLLISION_CLAMP_EN
      clamp_x_q   <= '0;
      clamp_y_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      obj_x_q     <= obj_x_d;
      obj_y_q     <= obj_y_d;
      obj_w_q     <= obj_w_d;
      obj_h_q     <= obj_h_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      acc_hit_q   <= acc_hit_d;
      acc_idx_q   <= acc_idx_d;
      result_q    <= result_d;
      hit_valid_q <= hit_valid_d;
      hit_idx_q   <= hit_idx_d;
`ifdef COLLISION_CLAMP_EN
      clamp_x_q   <= clamp_x_d;
      clamp_y_q   <= clamp_y_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (last)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values. The result registers load on the edge that enters
  // DONE, so they already hold the final scan result during the done pulse.
  always_comb begin
    obj_x_d     = obj_x_q;
    obj_y_d     = obj_y_q;
    obj_w_d     = obj_w_q;
    obj_h_d     = obj_h_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    acc_hit_d   = acc_hit_q;
    acc_idx_d   = acc_idx_q;
    result_d    = result_q;
    hit_valid_d = hit_valid_q;
    hit_idx_d   = hit_idx_q;
`ifdef COLLISION_CLAMP_EN
    clamp_x_d   = clamp_x_q;
    clamp_y_d   = clamp_y_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          obj_x_d   = x_in;
          obj_y_d   = y_in;
          obj_w_d   = obj_w;
          obj_h_d   = obj_h;
          idx_d     = '0;
          acc_d     = COLL_NONE;
          acc_hit_d = 1'b0;
          acc_idx_d = '0;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q | code;
        if (code != COLL_NONE && !acc_hit_q) begin
          acc_hit_d = 1'b1;
          acc_idx_d = idx_q;
        end
        if (last) begin
          idx_d       = '0;
          result_d    = acc_d;
          hit_valid_d = acc_hit_d;
          hit_idx_d   = acc_idx_d;
`ifdef COLLISION_CLAMP_EN
          clamp_x_d   = obj_x_q;
          clamp_y_d   = obj_y_q;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    busy      = (state_q == ST_SCAN);
    done      = (state_q == ST_DONE);
    plat_idx  = idx_q;
    result    = result_q;
    hit_valid = hit_valid_q;
    hit_idx   = hit_idx_q;
`ifdef COLLISION_CLAMP_EN
    clamp_x   = clamp_x_q;
    clamp_y   = clamp_y_q;
`endif
  end

endmodule
